// File: rtl/hdmi_lock_supervisor.sv
`timescale 1ns/1ps
// Supervises HDMI bit-synchronizer lock: resync pulse, bounded acquire with retries, loss/slip relock.
// Latency: every output is registered, one i_pix_clk edge after the sampled i_enable/i_sync_word.
// Backpressure: none; status is sampled every cycle and the block never stalls.
module hdmi_lock_supervisor #(
    parameter int RESET_CYCLES   = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int LOSS_CYCLES    = 4,
    parameter int MAX_RETRIES    = 7
) (
    input  logic        i_pix_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic [31:0] i_sync_word,
    output logic        o_sync_reset,
    output logic        o_locked,
    output logic        o_fail,
    output logic [15:0] o_relock_count,
    output logic [31:0] o_status
);

    localparam int RW = (RESET_CYCLES   > 0) ? $clog2(RESET_CYCLES + 1)   : 1;
    localparam int SW = (STABLE_CYCLES  > 0) ? $clog2(STABLE_CYCLES + 1)  : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LW = (LOSS_CYCLES    > 0) ? $clog2(LOSS_CYCLES + 1)    : 1;
    localparam int YW = (MAX_RETRIES    > 0) ? $clog2(MAX_RETRIES + 1)    : 1;

    localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STB_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CYCLES - 1);
    localparam logic [YW-1:0] RETRY_MAX = YW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESYNC  = 3'd1,
        ACQUIRE = 3'd2,
        LOCKED  = 3'd3,
        FAILED  = 3'd4
    } state_t;

    state_t          state;
    logic [RW-1:0]   rst_cnt;
    logic [SW-1:0]   stable_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [LW-1:0]   loss_cnt;
    logic [YW-1:0]   retry_cnt;
    logic [3:0]      slip_r_q;
    logic [3:0]      slip_g_q;
    logic [3:0]      slip_b_q;

    logic all_lock;
    logic slip_moved;
    logic unused_word_bits;

    assign all_lock   = i_sync_word[20] & i_sync_word[12] & i_sync_word[4];
    assign slip_moved = (i_sync_word[19:16] != slip_r_q) ||
                        (i_sync_word[11:8]  != slip_g_q) ||
                        (i_sync_word[3:0]   != slip_b_q);
    assign unused_word_bits = ^{i_sync_word[31:21], i_sync_word[15:13], i_sync_word[7:5]};

    assign o_status = {state, o_fail, o_locked, 11'h0, o_relock_count};

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            o_sync_reset   <= 1'b1;
            o_locked       <= 1'b0;
            o_fail         <= 1'b0;
            o_relock_count <= '0;
            rst_cnt        <= '0;
            stable_cnt     <= '0;
            tmo_cnt        <= '0;
            loss_cnt       <= '0;
            retry_cnt      <= '0;
            slip_r_q       <= '0;
            slip_g_q       <= '0;
            slip_b_q       <= '0;
        end else if (!i_enable) begin
            // Disable abandons any state; the relock history survives.
            state        <= IDLE;
            o_sync_reset <= 1'b1;
            o_locked     <= 1'b0;
            o_fail       <= 1'b0;
            rst_cnt      <= '0;
            stable_cnt   <= '0;
            tmo_cnt      <= '0;
            loss_cnt     <= '0;
            retry_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= RESYNC;
                    o_sync_reset <= 1'b1;
                    rst_cnt      <= '0;
                end
                RESYNC: begin
                    if (rst_cnt == RST_LAST) begin
                        state        <= ACQUIRE;
                        o_sync_reset <= 1'b0;
                        stable_cnt   <= '0;
                        tmo_cnt      <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ACQUIRE: begin
                    tmo_cnt    <= tmo_cnt + 1'b1;
                    stable_cnt <= all_lock ? stable_cnt + 1'b1 : '0;
                    // Lock completion is tested first so it wins over a coincident timeout.
                    if (all_lock && stable_cnt == STB_LAST) begin
                        state     <= LOCKED;
                        o_locked  <= 1'b1;
                        retry_cnt <= '0;
                        loss_cnt  <= '0;
                        slip_r_q  <= i_sync_word[19:16];
                        slip_g_q  <= i_sync_word[11:8];
                        slip_b_q  <= i_sync_word[3:0];
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt    <= retry_cnt + 1'b1;
                            state        <= RESYNC;
                            o_sync_reset <= 1'b1;
                            rst_cnt      <= '0;
                        end else begin
                            state  <= FAILED;
                            o_fail <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    loss_cnt <= all_lock ? '0 : loss_cnt + 1'b1;
                    if ((all_lock && slip_moved) || (!all_lock && loss_cnt == LOSS_LAST)) begin
                        state        <= RESYNC;
                        o_locked     <= 1'b0;
                        o_sync_reset <= 1'b1;
                        rst_cnt      <= '0;
                        loss_cnt     <= '0;
                        if (o_relock_count != 16'hFFFF) begin
                            o_relock_count <= o_relock_count + 16'd1;
                        end
                    end
                end
                FAILED: begin
                    o_fail       <= 1'b1;
                    o_sync_reset <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    o_sync_reset <= 1'b1;
                    o_locked     <= 1'b0;
                    o_fail       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_lock_supervisor.sv
`timescale 1ns/1ps
// Bench for hdmi_lock_supervisor: vector table, directed corner sequences, then random stimulus
// checked against a history-based reference model.
module tb_hdmi_lock_supervisor;

    localparam int RC = 4;
    localparam int SC = 8;
    localparam int TC = 32;
    localparam int LC = 3;
    localparam int MR = 2;

    localparam int P_IDLE   = 0;
    localparam int P_RESYNC = 1;
    localparam int P_ACQ    = 2;
    localparam int P_LOCKED = 3;
    localparam int P_FAILED = 4;

    localparam logic [31:0] W0      = 32'h0000_0000;
    localparam logic [31:0] W_LOCK  = 32'h0013_1010;
    localparam logic [31:0] W_GDROP = 32'h0013_0010;
    localparam logic [31:0] W_SLIP5 = 32'h0015_1010;

    logic        i_pix_clk = 1'b0;
    logic        i_reset_n;
    logic        i_enable;
    logic [31:0] i_sync_word;
    logic        o_sync_reset;
    logic        o_locked;
    logic        o_fail;
    logic [15:0] o_relock_count;
    logic [31:0] o_status;

    hdmi_lock_supervisor #(
        .RESET_CYCLES  (RC),
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TC),
        .LOSS_CYCLES   (LC),
        .MAX_RETRIES   (MR)
    ) dut (
        .i_pix_clk     (i_pix_clk),
        .i_reset_n     (i_reset_n),
        .i_enable      (i_enable),
        .i_sync_word   (i_sync_word),
        .o_sync_reset  (o_sync_reset),
        .o_locked      (o_locked),
        .o_fail        (o_fail),
        .o_relock_count(o_relock_count),
        .o_status      (o_status)
    );

    always #5 i_pix_clk = ~i_pix_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase plus the lock history since the phase began.
    int         m_phase;
    int         m_failed;
    int         m_relocks;
    bit         m_hist[$];
    logic [3:0] m_slip[3];

    typedef struct {
        logic        en;
        logic [31:0] w;
        logic [2:0]  st;
        logic        sr;
        logic        lk;
        logic        fl;
        logic [15:0] cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] view(input logic [2:0] st, input logic sr, input logic lk,
                                         input logic fl, input logic [15:0] cnt);
        return {10'b0, st, sr, lk, fl, cnt};
    endfunction

    function automatic logic [31:0] dut_view();
        return view(o_status[31:29], o_sync_reset, o_locked, o_fail, o_relock_count);
    endfunction

    function automatic int trailing_run(input bit val);
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != val) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_failed  = 0;
        m_relocks = 0;
        m_hist.delete();
        for (int i = 0; i < 3; i++) m_slip[i] = 4'h0;
    endtask

    task automatic model_relock();
        if (m_relocks < 65535) m_relocks++;
        m_phase = P_RESYNC;
        m_hist.delete();
    endtask

    task automatic model_step(input logic en, input logic [31:0] w);
        bit         lk;
        logic [3:0] s[3];
        lk   = w[20] & w[12] & w[4];
        s[0] = w[19:16];
        s[1] = w[11:8];
        s[2] = w[3:0];
        if (!en) begin
            m_phase  = P_IDLE;
            m_failed = 0;
            m_hist.delete();
        end else begin
            case (m_phase)
                P_IDLE: begin
                    m_phase = P_RESYNC;
                    m_hist.delete();
                end
                P_RESYNC: begin
                    m_hist.push_back(1'b0);
                    if (m_hist.size() == RC) begin
                        m_phase = P_ACQ;
                        m_hist.delete();
                    end
                end
                P_ACQ: begin
                    m_hist.push_back(lk);
                    if (trailing_run(1'b1) == SC) begin
                        m_phase  = P_LOCKED;
                        m_failed = 0;
                        m_slip   = s;
                        m_hist.delete();
                    end else if (m_hist.size() == TC) begin
                        if (m_failed < MR) begin
                            m_failed++;
                            m_phase = P_RESYNC;
                        end else begin
                            m_phase = P_FAILED;
                        end
                        m_hist.delete();
                    end
                end
                P_LOCKED: begin
                    if (lk && (s[0] != m_slip[0] || s[1] != m_slip[1] || s[2] != m_slip[2])) begin
                        model_relock();
                    end else begin
                        m_hist.push_back(lk);
                        if (trailing_run(1'b0) == LC) model_relock();
                        else if (m_hist.size() > 8) void'(m_hist.pop_front());
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [2:0] ph = m_phase[2:0];
        return {ph, m_phase == P_FAILED, m_phase == P_LOCKED, 11'h0, m_relocks[15:0]};
    endfunction

    function automatic logic [31:0] exp_flags();
        return {29'b0, m_phase <= P_RESYNC, m_phase == P_LOCKED, m_phase == P_FAILED};
    endfunction

    task automatic tick(input logic en, input logic [31:0] w);
        i_enable    = en;
        i_sync_word = w;
        @(posedge i_pix_clk);
        if (!i_reset_n) model_reset();
        else model_step(en, w);
        #1;
        check("model_status", o_status, exp_status());
        check("model_flags", {29'b0, o_sync_reset, o_locked, o_fail}, exp_flags());
    endtask

    task automatic add_vec(input logic en, input logic [31:0] w, input logic [2:0] st,
                           input logic sr, input logic lk, input logic fl, input logic [15:0] cnt);
        vec_t v;
        v.en = en; v.w = w; v.st = st; v.sr = sr; v.lk = lk; v.fl = fl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   fail_at   = -1;
        int   runs      = 0;
        int   run_cyc   = 0;
        bit   prev_rs   = 1'b0;
        bit   good      = 1'b1;
        logic [3:0] sr_v = 4'h3;
        logic [3:0] sg_v = 4'h0;
        logic [3:0] sb_v = 4'h0;
        logic lr, lg, lb;
        logic en;
        logic [31:0] w;

        // Enable with locks, then G-lock dropouts of 2 and 3 cycles.
        add_vec(1'b0, W0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) add_vec(1'b1, W_LOCK,  3'd1, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 8; i++) add_vec(1'b1, W_LOCK,  3'd2, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++) add_vec(1'b1, W_LOCK,  3'd3, 1'b0, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 2; i++) add_vec(1'b1, W_GDROP, 3'd3, 1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b1, W_LOCK, 3'd3, 1'b0, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 2; i++) add_vec(1'b1, W_GDROP, 3'd3, 1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b1, W_GDROP, 3'd1, 1'b1, 1'b0, 1'b0, 16'd1);
        add_vec(1'b1, W_LOCK,  3'd1, 1'b1, 1'b0, 1'b0, 16'd1);

        i_reset_n   = 1'b0;
        i_enable    = 1'b0;
        i_sync_word = W0;
        model_reset();
        repeat (3) @(posedge i_pix_clk);
        #1;
        check("reset_view", dut_view(), view(3'd0, 1'b1, 1'b0, 1'b0, 16'd0));
        check("reset_status", o_status, 32'h0);
        i_reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].en, vecs[i].w);
            check($sformatf("vec%0d", i), dut_view(),
                  view(vecs[i].st, vecs[i].sr, vecs[i].lk, vecs[i].fl, vecs[i].cnt));
        end

        // Reacquire, then an R slip change 3->5 with locks held.
        repeat (11) tick(1'b1, W_LOCK);
        check("reacquire_locked", dut_view(), view(3'd3, 1'b0, 1'b1, 1'b0, 16'd1));
        tick(1'b1, W_SLIP5);
        check("slip_relock", dut_view(), view(3'd1, 1'b1, 1'b0, 1'b0, 16'd2));

        // Lock completing exactly on the timeout cycle.
        repeat (4) tick(1'b1, W0);
        check("resync_done", dut_view(), view(3'd2, 1'b0, 1'b0, 1'b0, 16'd2));
        repeat (24) tick(1'b1, W0);
        repeat (7) tick(1'b1, W_LOCK);
        check("acq_cycle31", dut_view(), view(3'd2, 1'b0, 1'b0, 1'b0, 16'd2));
        tick(1'b1, W_LOCK);
        check("lock_at_timeout", dut_view(), view(3'd3, 1'b0, 1'b1, 1'b0, 16'd2));

        // Retries exhausted with locks never high.
        tick(1'b0, W0);
        check("disable_idle", dut_view(), view(3'd0, 1'b1, 1'b0, 1'b0, 16'd2));
        for (int t = 1; t <= 200 && fail_at < 0; t++) begin
            tick(1'b1, W0);
            if (o_status[31:29] == 3'd1) begin
                run_cyc++;
                if (!prev_rs) runs++;
            end
            prev_rs = (o_status[31:29] == 3'd1);
            if (o_fail) fail_at = t;
        end
        check("fail_tick", fail_at, 32'd109);
        check("resync_runs", runs, 32'd3);
        check("resync_cycles", run_cyc, 32'd12);
        check("failed_view", dut_view(), view(3'd4, 1'b0, 1'b0, 1'b1, 16'd2));
        repeat (3) tick(1'b1, W_LOCK);
        check("failed_hold", dut_view(), view(3'd4, 1'b0, 1'b0, 1'b1, 16'd2));
        tick(1'b0, W0);
        check("fail_exit_idle", dut_view(), view(3'd0, 1'b1, 1'b0, 1'b0, 16'd2));
        tick(1'b1, W0);
        check("fresh_resync", dut_view(), view(3'd1, 1'b1, 1'b0, 1'b0, 16'd2));

        // Asynchronous reset in the middle of ACQUIRE.
        repeat (4) tick(1'b1, W_LOCK);
        check("acq_before_reset", dut_view(), view(3'd2, 1'b0, 1'b0, 1'b0, 16'd2));
        repeat (2) tick(1'b1, W_LOCK);
        i_reset_n = 1'b0;
        #1;
        check("async_reset_view", dut_view(), view(3'd0, 1'b1, 1'b0, 1'b0, 16'd0));
        check("async_reset_status", o_status, 32'h0);
        model_reset();
        tick(1'b1, W_LOCK);
        i_reset_n = 1'b1;
        tick(1'b1, W_LOCK);
        check("release_first_edge", dut_view(), view(3'd1, 1'b1, 1'b0, 1'b0, 16'd0));

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) good = !good;
            if ($urandom_range(0, 63) == 0) sr_v = 4'($urandom);
            if ($urandom_range(0, 127) == 0) sg_v = 4'($urandom);
            if ($urandom_range(0, 127) == 0) sb_v = 4'($urandom);
            lr = good ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 1) == 1);
            lg = good ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 1) == 1);
            lb = good ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 1) == 1);
            w  = {11'($urandom), lr, sr_v, 3'($urandom), lg, sg_v, 3'($urandom), lb, sb_v};
            en = ($urandom_range(0, 299) != 0);
            i_reset_n = ($urandom_range(0, 999) != 0);
            tick(en, w);
        end
        i_reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_lock_supervisor.md
HDMI_LOCK_SUPERVISOR -- requirements
Module: hdmi_lock_supervisor

Interface
- REQ-001: Parameter RESET_CYCLES, default 16: number of cycles o_sync_reset is held during a resync pulse.
- REQ-002: Parameter STABLE_CYCLES, default 1024: number of consecutive all-locked cycles required to declare lock.
- REQ-003: Parameter TIMEOUT_CYCLES, default 65536: maximum number of cycles allowed in ACQUIRE per attempt.
- REQ-004: Parameter LOSS_CYCLES, default 4: number of consecutive not-locked cycles in LOCKED that constitute loss of lock.
- REQ-005: Parameter MAX_RETRIES, default 7: number of consecutive failed acquire attempts before FAILED.
- REQ-006: Port i_pix_clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-007: Port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-008: Port i_enable, input, 1 bit: supervision enable.
- REQ-009: Port i_sync_word, input, 32 bits: bit-synchronizer status; per-channel 5-bit fields at [20:16] R, [12:8] G, [4:0] B; bit 4 of a field = channel locked; bits 3:0 = slip value.
- REQ-010: Port o_sync_reset, output, 1 bit: active-high reset to the bit synchronizer.
- REQ-011: Port o_locked, output, 1 bit: all channels are locked and stable.
- REQ-012: Port o_fail, output, 1 bit: retries are exhausted.
- REQ-013: Port o_relock_count, output, 16 bits: saturating count of lock losses.
- REQ-014: Port o_status, output, 32 bits: {state[2:0], o_fail, o_locked, 11'h0, o_relock_count}.

Function
- REQ-015: The FSM state register SHALL use 3 bits, encoded IDLE=0, RESYNC=1, ACQUIRE=2, LOCKED=3, FAILED=4.
- REQ-016: all_lock SHALL be i_sync_word[20] & [12] & [4], sampled the same cycle.
- REQ-017: i_enable low in any state SHALL force IDLE on the next edge and clear the retry, stable, timeout and loss counters; o_relock_count SHALL be unaffected.
- REQ-018: IDLE SHALL hold o_sync_reset=1; i_enable high SHALL move the FSM to RESYNC.
- REQ-019: RESYNC SHALL assert o_sync_reset for exactly RESET_CYCLES cycles, then enter ACQUIRE with the stable and timeout counters at 0.
- REQ-020: In ACQUIRE, the stable counter SHALL increment when all_lock=1 and clear to 0 when all_lock=0; the timeout counter SHALL increment every cycle.
- REQ-021: ACQUIRE->LOCKED SHALL occur on the edge where the stable counter reaches STABLE_CYCLES; o_locked asserts that edge, i.e. STABLE_CYCLES cycles after the first of the consecutive locked samples.
- REQ-022: On the TIMEOUT_CYCLES-th ACQUIRE cycle without lock: if retries < MAX_RETRIES, retries SHALL increment and the FSM SHALL enter RESYNC; otherwise the FSM SHALL enter FAILED.
- REQ-023: If lock completion and timeout coincide on the same cycle, LOCKED SHALL win.
- REQ-024: On entry to LOCKED, the retry counter SHALL clear and the three 4-bit slip values SHALL be latched.
- REQ-025: In LOCKED, the loss counter SHALL count consecutive all_lock=0 cycles and clear on all_lock=1; reaching LOSS_CYCLES SHALL trigger relock.
- REQ-026: In LOCKED, any slip value differing from its latched value while all_lock=1 SHALL trigger immediate relock on the next edge.
- REQ-027: Relock SHALL mean LOCKED->RESYNC, o_locked=0 on the same edge, and o_relock_count+1, saturating at 16'hFFFF.
- REQ-028: FAILED SHALL hold o_fail=1 and o_sync_reset=0; the FSM SHALL leave FAILED only via i_enable low (to IDLE).
- REQ-029: All outputs SHALL be registered; o_locked=1 only in LOCKED; o_fail=1 only in FAILED; o_sync_reset=1 only in IDLE and RESYNC.
- REQ-030: All counters SHALL be sized to hold their parameter value, with no wrap inside a state.

Reset
- REQ-031: i_reset_n low SHALL asynchronously force state=IDLE, o_sync_reset=1, o_locked=0, o_fail=0, o_relock_count=0, and all counters to 0.
- REQ-032: Release of i_reset_n SHALL take effect on the first i_pix_clk edge with i_reset_n high.
- REQ-033: Reset asserted mid-operation, in any state, SHALL abandon that state immediately with no further o_sync_reset pulse sequencing.

Verification
Bench parameters: RESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, LOSS_CYCLES=3, MAX_RETRIES=2.
- REQ-034: Enable with locks high from cycle 0 of ACQUIRE -> o_sync_reset high for 4 cycles after IDLE; o_locked rises 8 cycles into ACQUIRE; o_status[31:29]=3.
- REQ-035: Locks never high -> 3 RESYNC pulses of 4 cycles each, then FAILED with o_fail=1 and o_sync_reset=0; i_enable low then high -> IDLE, then a fresh RESYNC.
- REQ-036: In LOCKED, drop the G lock for 2 cycles then restore -> o_locked stays high; drop it for 3 cycles -> o_locked falls on the 3rd edge and o_relock_count=1.
- REQ-037: In LOCKED, change the R slip value 3->5 with locks held -> RESYNC on the next edge and o_relock_count increments.
- REQ-038: Lock achieved on the 32nd ACQUIRE cycle (the timeout cycle) -> the FSM enters LOCKED, not RESYNC.
- REQ-039: Assert i_reset_n low mid-ACQUIRE -> outputs take reset values before the next edge; o_relock_count=0.
